// File: rtl/des_key_sched_seq.sv
// Purpose : iterative DES round-key generator with one PC-1, one C/D register pair and one PC-2 shared by all rounds.
// Latency : first key 1 cycle after an accepted start, then 1 key per cycle with back-to-back handshakes.
// Backpressure: key and round_idx hold while rk_valid && !rk_ready; abort returns to IDLE from any state.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   start, decrypt, KEY  schedule request; decrypt and KEY are captured only when start is accepted in IDLE
//   abort                synchronous return to IDLE; overrides start and handshake, no done pulse
//   rk_valid, rk_ready   round-key handshake
//   RoundKeyOut          PC-2 of the current C/D registers (combinational from registers)
//   round_idx            DES round number minus 1 of the presented key
//   busy                 high outside IDLE
//   done                 one-cycle pulse after the final key is accepted
//   key_err              odd-parity failure on KEY at start (only with KEY_PARITY_CHECK_EN, else tied 0)
//
// Build option: define KEY_PARITY_CHECK_EN to reject keys whose bytes are not odd parity.

module des_key_sched_seq #(
   parameter int          NUM_ROUNDS  = 16,
   parameter logic [15:0] SHIFT_SCHED = 16'h8103,
   parameter int          IDX_W       = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             decrypt,
   input  logic             abort,
   input  logic [63:0]      KEY,
   input  logic             rk_ready,
   output logic             rk_valid,
   output logic [47:0]      RoundKeyOut,
   output logic [IDX_W-1:0] round_idx,
   output logic             busy,
   output logic             done,
   output logic             key_err
);

   // Permuted choice tables in DES bit numbering (bit 1 = MSB).
   localparam int PC1_TAB [56] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
   };

   localparam int PC2_TAB [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
   };

   // Net rotation from PC-1 to the last round key; decrypt starts there.
   function automatic int f_total_rot(input int n);
      int s;
      s = 0;
      for (int i = 0; i < n; i++) begin
         s += SHIFT_SCHED[4'(i)] ? 1 : 2;
      end
      return s % 28;
   endfunction

   localparam logic [4:0]       ENC_INIT_ROT = SHIFT_SCHED[0] ? 5'd1 : 5'd2;
   localparam logic [4:0]       DEC_INIT_ROT = 5'(f_total_rot(NUM_ROUNDS));
   localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_ROUNDS - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_FIN
   } state_t;

   function automatic logic [55:0] f_pc1(input logic [63:0] k);
      logic [55:0] o;
      o = '0;
      for (int j = 0; j < 56; j++) begin
         o[6'(55 - j)] = k[6'(64 - PC1_TAB[j])];
      end
      return o;
   endfunction

   function automatic logic [47:0] f_pc2(input logic [55:0] cd);
      logic [47:0] o;
      o = '0;
      for (int j = 0; j < 48; j++) begin
         o[6'(47 - j)] = cd[6'(56 - PC2_TAB[j])];
      end
      return o;
   endfunction

   // Left rotation of a 28-bit half by 0..27; n=0 leaves x unchanged.
   function automatic logic [27:0] f_rotl(input logic [27:0] x, input logic [4:0] n);
      return (x << n) | (x >> (5'd28 - n));
   endfunction

   state_t           r_state;
   logic [27:0]      r_c;
   logic [27:0]      r_d;
   logic [IDX_W-1:0] r_idx;
   logic [IDX_W-1:0] r_cnt;
   logic             r_dec;
   logic             r_valid;
   logic             r_busy;
   logic             r_done;

   logic [55:0]      w_pc1;
   logic [4:0]       w_init_rot;
   logic [27:0]      w_init_c;
   logic [27:0]      w_init_d;
   logic [3:0]       w_enc_sel;
   logic [3:0]       w_dec_sel;
   logic             w_one;
   logic [27:0]      w_nxt_c;
   logic [27:0]      w_nxt_d;
   logic             w_par_ok;
   logic             w_last;

   assign w_pc1      = f_pc1(KEY);
   assign w_init_rot = decrypt ? DEC_INIT_ROT : ENC_INIT_ROT;
   assign w_init_c   = f_rotl(w_pc1[55:28], w_init_rot);
   assign w_init_d   = f_rotl(w_pc1[27:0],  w_init_rot);

   // Encrypt moves to round idx+2 (schedule bit idx+1); decrypt undoes the
   // rotation of the current round idx+1 (schedule bit idx).
   assign w_enc_sel = 4'(r_idx + IDX_W'(1));
   assign w_dec_sel = 4'(r_idx);
   assign w_one     = r_dec ? SHIFT_SCHED[w_dec_sel] : SHIFT_SCHED[w_enc_sel];

   always_comb begin
      w_nxt_c = r_c;
      w_nxt_d = r_d;
      if (r_dec) begin
         if (w_one) begin
            w_nxt_c = {r_c[0], r_c[27:1]};
            w_nxt_d = {r_d[0], r_d[27:1]};
         end else begin
            w_nxt_c = {r_c[1:0], r_c[27:2]};
            w_nxt_d = {r_d[1:0], r_d[27:2]};
         end
      end else begin
         if (w_one) begin
            w_nxt_c = {r_c[26:0], r_c[27]};
            w_nxt_d = {r_d[26:0], r_d[27]};
         end else begin
            w_nxt_c = {r_c[25:0], r_c[27:26]};
            w_nxt_d = {r_d[25:0], r_d[27:26]};
         end
      end
   end

   assign w_last = (r_cnt == LAST_IDX);

`ifdef KEY_PARITY_CHECK_EN
   // Every byte of the key must carry an odd number of ones.
   function automatic logic f_par_ok(input logic [63:0] k);
      logic [63:0] t;
      logic        ok;
      t  = k;
      ok = 1'b1;
      for (int b = 0; b < 8; b++) begin
         if (!(^t[7:0])) begin
            ok = 1'b0;
         end
         t = t >> 8;
      end
      return ok;
   endfunction

   logic r_key_err;

   assign w_par_ok = f_par_ok(KEY);
   assign key_err  = r_key_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_key_err <= 1'b0;
      end else if (!abort && (r_state == S_IDLE) && start) begin
         r_key_err <= !w_par_ok;
      end
   end
`else
   assign w_par_ok = 1'b1;
   assign key_err  = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_c     <= '0;
         r_d     <= '0;
         r_idx   <= '0;
         r_cnt   <= '0;
         r_dec   <= 1'b0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else if (abort) begin
         // C/D, index and count are left stale; the next start reloads them.
         r_state <= S_IDLE;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (start && w_par_ok) begin
                  r_c     <= w_init_c;
                  r_d     <= w_init_d;
                  r_dec   <= decrypt;
                  r_idx   <= decrypt ? LAST_IDX : '0;
                  r_cnt   <= '0;
                  r_valid <= 1'b1;
                  r_busy  <= 1'b1;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               if (rk_ready) begin
                  if (w_last) begin
                     r_valid <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= S_FIN;
                  end else begin
                     r_c   <= w_nxt_c;
                     r_d   <= w_nxt_d;
                     r_idx <= r_dec ? (r_idx - IDX_W'(1)) : (r_idx + IDX_W'(1));
                     r_cnt <= r_cnt + IDX_W'(1);
                  end
               end
            end
            S_FIN: begin
               // start is deliberately not looked at here.
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_valid <= 1'b0;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign RoundKeyOut = f_pc2({r_c, r_d});
   assign rk_valid    = r_valid;
   assign round_idx   = r_idx;
   assign busy        = r_busy;
   assign done        = r_done;

endmodule
